// File: rtl/mult_div_pkg.sv
// Shared widths and state encoding for the
// multiplier/divider benchmark family.
package mult_div_pkg;

  localparam int DW = 8;
  localparam int VW = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_restoring_step.sv
// One restoring-division step: shift in a dividend
// bit, trial-subtract the divisor, keep or restore.
module div_restoring_step #(
  parameter int VW = mult_div_pkg::VW
) (
  input  logic [VW-1:0] rem,
  input  logic          dbit,
  input  logic [VW-1:0] divisor,
  output logic [VW-1:0] rem_next,
  output logic          qbit
);

  logic [VW:0]   sh;
  logic [VW-1:0] diff;

  assign sh   = {rem, dbit};
  assign qbit = (sh >= {1'b0, divisor});
  // Result is < divisor whenever qbit is set,
  // so the dropped carry is always zero.
  assign diff     = sh[VW-1:0] - divisor;
  assign rem_next = qbit ? diff : sh[VW-1:0];

endmodule

// File: rtl/div_8x4_restoring_seq.sv
// Sequential restoring divider, one quotient bit
// per clock, valid/ready on both sides.
module div_8x4_restoring_seq #(
  parameter int DW = mult_div_pkg::DW,
  parameter int VW = mult_div_pkg::VW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div0
);

  import mult_div_pkg::*;

  localparam int CW = $clog2(DW);

  state_t        state;
  state_t        state_n;
  logic [DW-1:0] dvd;
  logic [VW-1:0] dsr;
  logic [VW-1:0] rem;
  logic [CW-1:0] cnt;
  logic [DW-1:0] q_r;
  logic [VW-1:0] r_r;
  logic          d0_r;
  logic [VW-1:0] rem_next;
  logic          qbit;
  logic          accept;
  logic          zdiv;

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign accept    = in_valid & in_ready;
  assign zdiv      = (divisor == '0);
  assign quotient  = q_r;
  assign remainder = r_r;
  assign div0      = d0_r;

  div_restoring_step #(.VW(VW)) u_step (
    .rem      (rem),
    .dbit     (dvd[DW-1]),
    .divisor  (dsr),
    .rem_next (rem_next),
    .qbit     (qbit)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE: begin
        if (accept)
          state_n = zdiv ? ST_DONE : ST_BUSY;
      end
      ST_BUSY: begin
        if (cnt == '0)
          state_n = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready)
          state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= ST_IDLE;
    else
      state <= state_n;
  end

  // Quotient bits accumulate in the dividend register.
  always_ff @(posedge clk) begin
    if (rst) begin
      dvd  <= '0;
      dsr  <= '0;
      rem  <= '0;
      cnt  <= '0;
      q_r  <= '0;
      r_r  <= '0;
      d0_r <= 1'b0;
    end else if (accept) begin
      dvd  <= dividend;
      dsr  <= divisor;
      rem  <= '0;
      cnt  <= CW'(DW - 1);
      d0_r <= zdiv;
      if (zdiv) begin
        q_r <= '1;
        r_r <= dividend[VW-1:0];
      end
    end else if (state == ST_BUSY) begin
      dvd <= {dvd[DW-2:0], qbit};
      rem <= rem_next;
      cnt <= cnt - 1'b1;
      if (cnt == '0) begin
        q_r <= {dvd[DW-2:0], qbit};
        r_r <= rem_next;
      end
    end
  end

endmodule

// File: tb/tb_div_8x4_restoring_seq.sv
// Randomised bench for the restoring divider with
// an arithmetic reference model and a cycle monitor.
module tb_div_8x4_restoring_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div0;

  int n_chk  = 0;
  int n_fail = 0;

  int exp_q;
  int exp_r;
  int exp_d0;
  bit inflight = 1'b0;
  bit mon_en   = 1'b0;

  int last_q;
  int last_r;
  int last_d0;

  div_8x4_restoring_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div0      (div0)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm,
                       input int act,
                       input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d @%0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference model: plain integer division.
  task automatic model(input int a, input int b);
    if (b == 0) begin
      exp_q  = 255;
      exp_r  = a % 16;
      exp_d0 = 1;
    end else begin
      exp_q  = a / b;
      exp_r  = a % b;
      exp_d0 = 0;
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("in_ready", int'(in_ready), int'(!inflight));
      if (!inflight)
        check("idle out_valid", int'(out_valid), 0);
      if (out_valid) begin
        check("quotient", int'(quotient), exp_q);
        check("remainder", int'(remainder), exp_r);
        check("div0", int'(div0), exp_d0);
      end
    end
  end

  task automatic run_op(input int a,
                        input int b,
                        input int stall);
    int lat;
    @(posedge clk);
    #1;
    in_valid  = 1'b1;
    dividend  = a[7:0];
    divisor   = b[3:0];
    out_ready = 1'b0;
    model(a, b);
    @(posedge clk);
    inflight = 1'b1;
    #1;
    in_valid = 1'($urandom_range(0, 1));
    dividend = 8'($urandom);
    divisor  = 4'($urandom);
    out_ready = 1'($urandom_range(0, 1)) & 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      if (lat == 3)
        out_ready = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
    out_ready = 1'b0;
    check("latency", lat, (b == 0) ? 0 : 8);
    last_q  = int'(quotient);
    last_r  = int'(remainder);
    last_d0 = int'(div0);
    if (b != 0) begin
      check("q*b+r", last_q * b + last_r, a);
      check("r<b", int'(last_r < b), 1);
    end
    repeat (stall) @(posedge clk);
    if (stall > 0) #1;
    out_ready = 1'b1;
    @(posedge clk);
    inflight = 1'b0;
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("out_valid drop", int'(out_valid), 0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    exp_q  = 0;
    exp_r  = 0;
    exp_d0 = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst in_ready", int'(in_ready), 1);
    check("rst out_valid", int'(out_valid), 0);
    check("rst quotient", int'(quotient), 0);
    check("rst remainder", int'(remainder), 0);
    check("rst div0", int'(div0), 0);
    mon_en = 1'b1;

    run_op(200, 7, 0);
    check("200/7 q", last_q, 28);
    check("200/7 r", last_r, 4);
    check("200/7 d0", last_d0, 0);

    run_op(255, 15, 1);
    check("255/15 q", last_q, 17);
    check("255/15 r", last_r, 0);

    run_op(0, 1, 0);
    check("0/1 q", last_q, 0);
    check("0/1 r", last_r, 0);

    run_op(13, 0, 2);
    check("13/0 q", last_q, 255);
    check("13/0 r", last_r, 13);
    check("13/0 d0", last_d0, 1);

    run_op(9, 3, 0);
    check("9/3 q", last_q, 3);
    check("9/3 r", last_r, 0);
    check("9/3 d0", last_d0, 0);

    run_op(100, 9, 5);
    check("100/9 q", last_q, 11);
    check("100/9 r", last_r, 1);

    // Reset in the 4th BUSY cycle abandons the op.
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    dividend = 8'd200;
    divisor  = 4'd7;
    model(200, 7);
    @(posedge clk);
    inflight = 1'b1;
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    inflight = 1'b0;
    #1;
    rst = 1'b0;
    check("mid rst out_valid", int'(out_valid), 0);
    check("mid rst in_ready", int'(in_ready), 1);
    check("mid rst quotient", int'(quotient), 0);
    check("mid rst remainder", int'(remainder), 0);
    check("mid rst div0", int'(div0), 0);

    run_op(50, 6, 0);
    check("50/6 q", last_q, 8);
    check("50/6 r", last_r, 2);

    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_op(a, b, int'($urandom_range(0, 2)));
      end
    end

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
